parity_engine: RTL
==================

Name: parity_engine

Overview:
Parametrised parity unit for the UART datapath; successor to the fixed 8-bit TX-only parity calculator. TX side snapshots a parallel word plus its configuration and drives the frame parity bit on request. RX side accumulates sampled serial bits, checks the received parity bit and keeps a saturating error count. Supports runtime data length and even/odd/mark/space parity.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (legal 5..16)
LEN_W, $clog2(DATA_WIDTH)+1, width of the DATA_LEN field
ERR_CNT_W, 8, width of the parity error counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
DATA_LEN  in  LEN_W  active data bits per frame, 1..DATA_WIDTH; 0 or >DATA_WIDTH treated as DATA_WIDTH
PAR_EN  in  1  1 = frame carries a parity bit
PAR_MODE  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
P_DATA  in  DATA_WIDTH  TX parallel word, LSB first
Data_valid  in  1  TX word valid
busy  in  1  TX serializer busy; blocks load
Enable_Par_Output  in  1  serializer in parity slot; update PAR_BIT
PAR_BIT  out  1  registered TX parity bit
rx_start  in  1  start-bit detected; begin new RX frame
rx_bit_valid  in  1  rx_bit is a sampled data/parity bit
rx_bit  in  1  sampled RX bit
PAR_DONE  out  1  one-cycle pulse: RX frame parity evaluation complete
PAR_ERR  out  1  one-cycle pulse with PAR_DONE when parity mismatched
err_cnt_clr  in  1  clear error counter
ERR_CNT  out  ERR_CNT_W  saturating count of RX parity errors

Behaviour:
- Reset (RST=1 at rising edge): PAR_BIT=0, PAR_DONE=0, PAR_ERR=0, ERR_CNT=0, TX data/config snapshot=0, RX state=RX_IDLE, bit counter=0, accumulator=0. Reset overrides all other inputs, including mid-frame.
- TX load: Data_valid && !busy -> snapshot P_DATA masked to DATA_LEN LSBs (upper bits forced 0), and DATA_LEN/PAR_EN/PAR_MODE. Later config changes do not affect the loaded word.
- TX update: Enable_Par_Output (and no load this cycle) -> PAR_BIT next cycle = even: ^data; odd: ~^data; mark: 1; space: 0; PAR_EN=0 in snapshot: 0. Otherwise PAR_BIT holds.
- Load and Enable_Par_Output in the same cycle: load wins, PAR_BIT holds old value.
- Data_valid while busy=1: ignored, snapshot unchanged.
- RX FSM states RX_IDLE, RX_DATA, RX_PAR:
  - any state, rx_start=1: snapshot config, accumulator=0, counter=0, -> RX_DATA (restarts an in-progress frame; no DONE for the aborted frame). rx_bit_valid in the same cycle is ignored.
  - RX_IDLE: rx_bit_valid ignored.
  - RX_DATA: each rx_bit_valid -> accumulator ^= rx_bit, counter+1. On the DATA_LEN-th bit: PAR_EN=1 -> RX_PAR; PAR_EN=0 -> RX_IDLE with PAR_DONE=1, PAR_ERR=0 next cycle.
  - RX_PAR: rx_bit_valid -> expected = even: acc; odd: ~acc; mark: 1; space: 0; PAR_DONE=1 next cycle, PAR_ERR=(rx_bit!=expected); -> RX_IDLE.
- PAR_DONE/PAR_ERR are registered, high exactly one cycle, 1-cycle latency after the final bit's rx_bit_valid.
- ERR_CNT increments on each PAR_ERR pulse, saturating at all-ones. err_cnt_clr forces 0; clear coincident with an error -> result 0 (clear wins).
- TX and RX halves are independent; simultaneous activity on both is legal.

Test Plan:
- RST mid-RX frame (3 of 8 bits received) -> all outputs 0, next rx_bit_valid with no rx_start produces no PAR_DONE.
- TX: DATA_LEN=8, even, P_DATA=0xA7 loaded, then Enable_Par_Output -> PAR_BIT=1. Odd mode -> 0. DATA_LEN=5, even, P_DATA=0xFF -> masked 0x1F -> PAR_BIT=1.
- TX: load 0x01 (even), change PAR_MODE to space, Enable_Par_Output -> PAR_BIT=1 (snapshot held). Data_valid with busy=1 carrying 0x03 -> ignored. Load and Enable_Par_Output in the same cycle -> PAR_BIT unchanged.
- RX: DATA_LEN=8, odd, bits of 0x55 then parity 1 -> PAR_DONE pulse, PAR_ERR=0. Parity 0 -> PAR_ERR=1, ERR_CNT=1. Mark mode with parity bit 0 -> error.
- RX: PAR_EN=0, DATA_LEN=7 -> PAR_DONE one cycle after the 7th bit, PAR_ERR=0. rx_start after 4 bits -> frame restarts, only one PAR_DONE.
- ERR_CNT_W=2: force 4 errors -> ERR_CNT stays 3. err_cnt_clr coincident with an error -> 0.

Source files
------------

// File: rtl/parity_engine_if.sv
// Parity engine signal bundle: TX load/parity slot, RX bit stream and status outputs.
// The engine takes the slave modport; the datapath driving it takes the master.
interface parity_engine_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH) + 1,
  parameter int unsigned ERR_CNT_W  = 8
);
  logic [LEN_W-1:0]      DATA_LEN;
  logic                  PAR_EN;
  logic [1:0]            PAR_MODE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_valid;
  logic                  busy;
  logic                  Enable_Par_Output;
  logic                  PAR_BIT;
  logic                  rx_start;
  logic                  rx_bit_valid;
  logic                  rx_bit;
  logic                  PAR_DONE;
  logic                  PAR_ERR;
  logic                  err_cnt_clr;
  logic [ERR_CNT_W-1:0]  ERR_CNT;

  modport slave (
    input  DATA_LEN, PAR_EN, PAR_MODE, P_DATA, Data_valid, busy, Enable_Par_Output,
    input  rx_start, rx_bit_valid, rx_bit, err_cnt_clr,
    output PAR_BIT, PAR_DONE, PAR_ERR, ERR_CNT
  );

  modport master (
    output DATA_LEN, PAR_EN, PAR_MODE, P_DATA, Data_valid, busy, Enable_Par_Output,
    output rx_start, rx_bit_valid, rx_bit, err_cnt_clr,
    input  PAR_BIT, PAR_DONE, PAR_ERR, ERR_CNT
  );
endinterface

// File: rtl/parity_engine.sv
// UART parity engine: TX parity bit from a snapshotted word, RX parity check with a
// saturating error counter. TX and RX halves run independently.
module parity_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = $clog2(DATA_WIDTH) + 1,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  parity_engine_if.slave bus
);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR} rx_state_t;

  localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(DATA_WIDTH);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  // Parity bit selection shared by both halves; acc is the XOR of the data bits.
  function automatic logic par_sel(input logic en, input logic [1:0] mode, input logic acc);
    logic res;
    res = 1'b0;
    if (en) begin
      case (mode)
        2'b00:   res = acc;
        2'b01:   res = ~acc;
        2'b10:   res = 1'b1;
        default: res = 1'b0;
      endcase
    end
    return res;
  endfunction

  logic [LEN_W-1:0]      w_len;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_tx_load;
  logic                  w_tx_par;
  logic                  w_rx_exp;
  logic [LEN_W-1:0]      w_rx_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_par_en;
  logic [1:0]            r_tx_mode;
  logic                  r_par_bit;

  rx_state_t             r_rx_state;
  logic [LEN_W-1:0]      r_rx_cnt;
  logic                  r_rx_acc;
  logic [LEN_W-1:0]      r_rx_len;
  logic                  r_rx_par_en;
  logic [1:0]            r_rx_mode;
  logic                  r_par_done;
  logic                  r_par_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  // Out-of-range lengths fall back to the full data width.
  assign w_len = ((bus.DATA_LEN == '0) || (bus.DATA_LEN > MAX_LEN)) ? MAX_LEN : bus.DATA_LEN;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      w_mask[i] = (LEN_W'(i) < w_len);
    end
  end

  assign w_tx_load    = bus.Data_valid && !bus.busy;
  assign w_tx_par     = par_sel(r_tx_par_en, r_tx_mode, ^r_tx_data);
  assign w_rx_exp     = par_sel(1'b1, r_rx_mode, r_rx_acc);
  assign w_rx_cnt_nxt = r_rx_cnt + LEN_W'(1);

  // TX: snapshot on load; a load in the same cycle as the parity slot keeps PAR_BIT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_data   <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_mode   <= 2'b00;
      r_par_bit   <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_data   <= bus.P_DATA & w_mask;
      r_tx_par_en <= bus.PAR_EN;
      r_tx_mode   <= bus.PAR_MODE;
    end else if (bus.Enable_Par_Output) begin
      r_par_bit   <= w_tx_par;
    end
  end

  // RX frame FSM; rx_start restarts from any state and masks a coincident bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_acc    <= 1'b0;
      r_rx_len    <= '0;
      r_rx_par_en <= 1'b0;
      r_rx_mode   <= 2'b00;
      r_par_done  <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_par_done <= 1'b0;
      r_par_err  <= 1'b0;
      if (bus.rx_start) begin
        r_rx_state  <= RX_DATA;
        r_rx_cnt    <= '0;
        r_rx_acc    <= 1'b0;
        r_rx_len    <= w_len;
        r_rx_par_en <= bus.PAR_EN;
        r_rx_mode   <= bus.PAR_MODE;
      end else begin
        case (r_rx_state)
          RX_DATA: begin
            if (bus.rx_bit_valid) begin
              r_rx_acc <= r_rx_acc ^ bus.rx_bit;
              r_rx_cnt <= w_rx_cnt_nxt;
              if (w_rx_cnt_nxt == r_rx_len) begin
                if (r_rx_par_en) begin
                  r_rx_state <= RX_PAR;
                end else begin
                  r_rx_state <= RX_IDLE;
                  r_par_done <= 1'b1;
                end
              end
            end
          end
          RX_PAR: begin
            if (bus.rx_bit_valid) begin
              r_rx_state <= RX_IDLE;
              r_par_done <= 1'b1;
              r_par_err  <= (bus.rx_bit != w_rx_exp);
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // Error counter counts PAR_ERR pulses; clear dominates a coincident pulse.
  always_ff @(posedge CLK) begin
    if (RST || bus.err_cnt_clr) begin
      r_err_cnt <= '0;
    end else if (r_par_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.PAR_BIT  = r_par_bit;
  assign bus.PAR_DONE = r_par_done;
  assign bus.PAR_ERR  = r_par_err;
  assign bus.ERR_CNT  = r_err_cnt;

endmodule
